// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: ID->EX control struct, vector operand type
// and the all-zero bubble constant.
package pipe_pkg;

    localparam int PIPE_N   = 8;
    localparam int PIPE_R   = 6;
    localparam int PIPE_AW  = 4;
    localparam int PIPE_ACW = 3;

    typedef logic [PIPE_R-1:0][PIPE_N-1:0] vec_t;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                memto_reg;
        logic                mem_write;
        logic                flags_write;
        logic [1:0]          vsi_flag;
        logic [PIPE_ACW-1:0] alu_control;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '0;

    // An empty slot must never carry write side effects into execute.
    function automatic idex_ctrl_t mask_ctrl(input idex_ctrl_t c);
        idex_ctrl_t r;
        r = c;
        if (!c.valid) begin
            r.reg_write   = 1'b0;
            r.memto_reg   = 1'b0;
            r.mem_write   = 1'b0;
            r.flags_write = 1'b0;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Negedge-captured W-bit field register with async active-high reset,
// synchronous clear (highest priority) and load enable.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next-state: clear beats load, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Field storage.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/segment_id_ex_ctl.sv
// ID->EX stage register with stall hold, flush bubble, valid bit and per-lane write mask.
// Optional saturating stall/bubble counters are enabled by defining SEG_PERF_CNT_EN.
module segment_id_ex_ctl
    import pipe_pkg::*;
#(
    parameter int N   = PIPE_N,
    parameter int R   = PIPE_R,
    parameter int AW  = PIPE_AW,
    parameter int ACW = PIPE_ACW
`ifdef SEG_PERF_CNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                ValidD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                FlagsWriteD,
    input  logic [1:0]          VSIFlagD,
    input  logic [ACW-1:0]      ALUControlD,
    input  logic [AW-1:0]       WA3D,
    input  logic [AW-1:0]       RA2D,
    input  logic [R-1:0][N-1:0] RD1D,
    input  logic [R-1:0][N-1:0] RD2D,
    input  logic [N-1:0]        ImmD,
    input  logic [R-1:0]        LaneEnD,
    output logic                ValidE,
    output logic                RegWriteE,
    output logic                MemtoRegE,
    output logic                MemWriteE,
    output logic                FlagsWriteE,
    output logic [1:0]          VSIFlagE,
    output logic [ACW-1:0]      ALUControlE,
    output logic [AW-1:0]       WA3E,
    output logic [AW-1:0]       RA2E,
    output logic [R-1:0][N-1:0] RD1E,
    output logic [R-1:0][N-1:0] RD2E,
    output logic [N-1:0]        ImmE,
    output logic [R-1:0]        LaneEnE
`ifdef SEG_PERF_CNT_EN
    , output logic [CW-1:0]     StallCnt
    , output logic [CW-1:0]     BubbleCnt
`endif
);

    localparam int ADDR_W = 2*AW + R;
    localparam int DATA_W = 2*R*N + N;

    idex_ctrl_t         ctrl_in_s;
    idex_ctrl_t         ctrl_out_s;
    logic [ADDR_W-1:0]  addr_in_s;
    logic [ADDR_W-1:0]  addr_out_s;
    logic [DATA_W-1:0]  data_in_s;
    logic [DATA_W-1:0]  data_out_s;
    logic               load_en_s;

    assign load_en_s = ~StallE;

    // Gather decode-side fields; write-side controls and lane mask are qualified by ValidD.
    always_comb begin
        ctrl_in_s             = IDEX_BUBBLE;
        ctrl_in_s.valid       = ValidD;
        ctrl_in_s.reg_write   = RegWriteD;
        ctrl_in_s.memto_reg   = MemtoRegD;
        ctrl_in_s.mem_write   = MemWriteD;
        ctrl_in_s.flags_write = FlagsWriteD;
        ctrl_in_s.vsi_flag    = VSIFlagD;
        ctrl_in_s.alu_control = ALUControlD;
        ctrl_in_s             = mask_ctrl(ctrl_in_s);
        addr_in_s             = {WA3D, RA2D, LaneEnD & {R{ValidD}}};
        data_in_s             = {RD1D, RD2D, ImmD};
    end

    pipe_field_reg #(.W($bits(idex_ctrl_t))) u_ctrl_reg (
        .clk(clk), .reset(reset), .clr(FlushE), .en(load_en_s),
        .d(ctrl_in_s), .q(ctrl_out_s)
    );

    pipe_field_reg #(.W(ADDR_W)) u_addr_reg (
        .clk(clk), .reset(reset), .clr(FlushE), .en(load_en_s),
        .d(addr_in_s), .q(addr_out_s)
    );

    pipe_field_reg #(.W(DATA_W)) u_data_reg (
        .clk(clk), .reset(reset), .clr(FlushE), .en(load_en_s),
        .d(data_in_s), .q(data_out_s)
    );

    assign ValidE               = ctrl_out_s.valid;
    assign RegWriteE            = ctrl_out_s.reg_write;
    assign MemtoRegE            = ctrl_out_s.memto_reg;
    assign MemWriteE            = ctrl_out_s.mem_write;
    assign FlagsWriteE          = ctrl_out_s.flags_write;
    assign VSIFlagE             = ctrl_out_s.vsi_flag;
    assign ALUControlE          = ctrl_out_s.alu_control;
    assign {WA3E, RA2E, LaneEnE} = addr_out_s;
    assign {RD1E, RD2E, ImmE}   = data_out_s;

`ifdef SEG_PERF_CNT_EN
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] stall_cnt_d;
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] bubble_cnt_d;
    logic [CW-1:0] bubble_cnt_q;

    // Saturating event counters; a load of an empty slot counts as a bubble.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (StallE && !FlushE && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if ((FlushE || (!StallE && !ValidD)) && (bubble_cnt_q != {CW{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter storage.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_segment_id_ex_ctl.sv
// Self-checking bench for segment_id_ex_ctl: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage register.
module tb_segment_id_ex_ctl;

    localparam int N   = 8;
    localparam int R   = 6;
    localparam int AW  = 4;
    localparam int ACW = 3;
    localparam int CW  = 4;
    localparam int VW  = R*N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic StallE = 1'b0, FlushE = 1'b0, ValidD = 1'b0;
    logic RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0, FlagsWriteD = 1'b0;
    logic [1:0]     VSIFlagD = 2'd0;
    logic [ACW-1:0] ALUControlD = 3'd0;
    logic [AW-1:0]  WA3D = 4'd0, RA2D = 4'd0;
    logic [VW-1:0]  RD1D = '0, RD2D = '0;
    logic [N-1:0]   ImmD = 8'd0;
    logic [R-1:0]   LaneEnD = 6'd0;

    logic ValidE, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE;
    logic [1:0]     VSIFlagE;
    logic [ACW-1:0] ALUControlE;
    logic [AW-1:0]  WA3E, RA2E;
    logic [VW-1:0]  RD1E, RD2E;
    logic [N-1:0]   ImmE;
    logic [R-1:0]   LaneEnE;
`ifdef SEG_PERF_CNT_EN
    logic [CW-1:0]  StallCnt, BubbleCnt;
`endif

    segment_id_ex_ctl #(
        .N(N), .R(R), .AW(AW), .ACW(ACW)
`ifdef SEG_PERF_CNT_EN
        , .CW(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .FlagsWriteD(FlagsWriteD), .VSIFlagD(VSIFlagD), .ALUControlD(ALUControlD),
        .WA3D(WA3D), .RA2D(RA2D), .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .LaneEnD(LaneEnD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .FlagsWriteE(FlagsWriteE), .VSIFlagE(VSIFlagE), .ALUControlE(ALUControlE),
        .WA3E(WA3E), .RA2E(RA2E), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .LaneEnE(LaneEnE)
`ifdef SEG_PERF_CNT_EN
        , .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: what the execute side should see, plus event counts.
    logic          m_valid, m_rw, m_m2r, m_mw, m_fw;
    logic [1:0]    m_vsi;
    logic [2:0]    m_alu;
    logic [3:0]    m_wa3, m_ra2;
    logic [5:0]    m_lane;
    logic [VW-1:0] m_rd1, m_rd2;
    logic [7:0]    m_imm;
    int            m_stalls, m_bubbles;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        {m_valid, m_rw, m_m2r, m_mw, m_fw} = 5'b0;
        m_vsi = 2'd0; m_alu = 3'd0; m_wa3 = 4'd0; m_ra2 = 4'd0; m_lane = 6'd0;
        m_rd1 = '0; m_rd2 = '0; m_imm = 8'd0;
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // One falling edge as the pipeline sees it: flush bubbles, stall holds, otherwise load.
    function automatic void model_edge();
        if (reset) begin
            model_clear();
            m_stalls = 0; m_bubbles = 0;
        end else if (FlushE) begin
            model_clear();
            m_bubbles = sat(m_bubbles + 1);
        end else if (StallE) begin
            m_stalls = sat(m_stalls + 1);
        end else begin
            m_valid = ValidD;
            m_rw  = ValidD && RegWriteD;
            m_m2r = ValidD && MemtoRegD;
            m_mw  = ValidD && MemWriteD;
            m_fw  = ValidD && FlagsWriteD;
            m_lane = ValidD ? LaneEnD : 6'd0;
            m_vsi = VSIFlagD; m_alu = ALUControlD; m_wa3 = WA3D; m_ra2 = RA2D;
            m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmD;
            if (!ValidD) m_bubbles = sat(m_bubbles + 1);
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(ValidE), 64'(m_valid));
        check({tag, ".ctl"}, 64'({RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE}),
              64'({m_rw, m_m2r, m_mw, m_fw}));
        check({tag, ".vsi_alu"}, 64'({VSIFlagE, ALUControlE}), 64'({m_vsi, m_alu}));
        check({tag, ".addr"}, 64'({WA3E, RA2E}), 64'({m_wa3, m_ra2}));
        check({tag, ".lane"}, 64'(LaneEnE), 64'(m_lane));
        check({tag, ".rd1"}, 64'(RD1E), 64'(m_rd1));
        check({tag, ".rd2"}, 64'(RD2E), 64'(m_rd2));
        check({tag, ".imm"}, 64'(ImmE), 64'(m_imm));
        check({tag, ".inv"}, ValidE ? 64'd0 : 64'({RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE, LaneEnE}), 64'd0);
`ifdef SEG_PERF_CNT_EN
        check({tag, ".stallcnt"}, 64'(StallCnt), 64'(m_stalls));
        check({tag, ".bubblecnt"}, 64'(BubbleCnt), 64'(m_bubbles));
`endif
    endtask

    // Advance one falling edge, update the model, then compare well clear of the edge.
    task automatic step(input string tag);
        @(negedge clk);
        model_edge();
        #2;
        check_all(tag);
    endtask

    task automatic drive_instr(input logic v, input logic [2:0] alu, input logic [3:0] wa3,
                               input logic [7:0] imm, input logic [VW-1:0] rd1);
        ValidD = v; RegWriteD = 1'b1; MemtoRegD = 1'b0; MemWriteD = 1'b1; FlagsWriteD = 1'b1;
        VSIFlagD = 2'd2; ALUControlD = alu; WA3D = wa3; RA2D = 4'h9; ImmD = imm;
        RD1D = rd1; RD2D = ~rd1; LaneEnD = 6'h2D;
    endtask

    task automatic randomize_inputs();
        StallE = ($urandom_range(0, 3) == 0);
        FlushE = ($urandom_range(0, 7) == 0);
        ValidD = ($urandom_range(0, 3) != 0);
        {RegWriteD, MemtoRegD, MemWriteD, FlagsWriteD} = 4'($urandom());
        VSIFlagD = 2'($urandom()); ALUControlD = 3'($urandom());
        WA3D = 4'($urandom()); RA2D = 4'($urandom());
        RD1D = VW'({$urandom(), $urandom()}); RD2D = VW'({$urandom(), $urandom()});
        ImmD = 8'($urandom()); LaneEnD = 6'($urandom());
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_clear(); m_stalls = 0; m_bubbles = 0;
        check_all({tag, ".imm0"});
        step({tag, ".edge"});
        #1 reset = 1'b0;
    endtask

    int s0, b0;

    initial begin
        model_clear(); m_stalls = 0; m_bubbles = 0;
        reset = 1'b1;
        #12 reset = 1'b0;

        // 1: reset arriving while a load is pending.
        drive_instr(1'b1, 3'b011, 4'h2, 8'h55, {R{8'hA5}});
        step("t1.pre");
        async_reset("t1");

        // 2: plain load, one negedge latency.
        drive_instr(1'b1, 3'b101, 4'h7, 8'h3C, {R{8'h5A}});
        step("t2");
        check("t2.alu", 64'(ALUControlE), 64'd5);
        check("t2.wa3", 64'(WA3E), 64'h7);
        check("t2.imm", 64'(ImmE), 64'h3C);

        // 3: load A, then stall three edges with B on D, B lands on the fourth.
        drive_instr(1'b1, 3'b001, 4'h3, 8'hAA, {R{8'h12}});
        step("t3.A");
        s0 = m_stalls;
        drive_instr(1'b1, 3'b110, 4'hC, 8'hBB, {R{8'h34}});
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t3.hold");
            check("t3.heldA", 64'(ImmE), 64'hAA);
        end
`ifdef SEG_PERF_CNT_EN
        check("t3.stallcnt3", 64'(StallCnt), 64'(s0 + 3));
`endif
        StallE = 1'b0;
        step("t3.B");
        check("t3.Bimm", 64'(ImmE), 64'hBB);

        // 4: flush and stall together insert a bubble.
        b0 = m_bubbles;
        FlushE = 1'b1; StallE = 1'b1;
        step("t4");
        check("t4.bubble", 64'({ValidE, RegWriteE, MemWriteE, LaneEnE, RD1E}), 64'd0);
`ifdef SEG_PERF_CNT_EN
        check("t4.bubblecnt", 64'(BubbleCnt), 64'(b0 + 1));
`endif
        FlushE = 1'b0; StallE = 1'b0;

        // 5: empty slot still moves data but no write controls.
        drive_instr(1'b0, 3'b010, 4'h5, 8'h77, {R{8'h22}});
        LaneEnD = 6'h3F; RD2D = {R{8'h11}};
        step("t5");
        check("t5.ctl", 64'({RegWriteE, MemWriteE, LaneEnE}), 64'd0);
        check("t5.rd2", 64'(RD2E), 64'({R{8'h11}}));

        // 6: long stall saturates the stall counter.
        StallE = 1'b1;
        for (int i = 0; i < 20; i++) step("t6");
`ifdef SEG_PERF_CNT_EN
        check("t6.sat", 64'(StallCnt), 64'hF);
`endif
        StallE = 1'b0;

        // Randomized traffic, with occasional mid-cycle reset (including during stalls).
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 49) == 0) async_reset("rnd.rst");
            else step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
